pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/halt controller: IDLE/RUN/DRAIN/HALTED FSM with load-use stall and branch flush.
// Define PIPE_CTRL_PERF_EN to build the stall/flush performance counters.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        branch_taken,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        done,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [1:0] r_drainCnt;
  logic [1:0] w_nextDrainCnt;
  logic       r_armed;

  logic [6:0] w_opcode;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_rs1Used;
  logic       w_rs2Used;
  logic       w_halt;
  logic       w_loadUse;

  assign w_opcode = id_instr[6:0];
  assign w_rs1    = id_instr[19:15];
  assign w_rs2    = id_instr[24:20];

  // Only sources the opcode actually reads can create a load-use hazard.
  assign w_rs1Used = !((w_opcode == 7'b0110111) || (w_opcode == 7'b0010111) ||
                       (w_opcode == 7'b1101111));
  assign w_rs2Used = (w_opcode == 7'b0110011) || (w_opcode == 7'b0111011) ||
                     (w_opcode == 7'b0100011) || (w_opcode == 7'b1100011);

  assign w_halt = id_valid && ((id_instr == 32'h0000_0073) || (id_instr == 32'h0000_0000));

  assign w_loadUse = id_valid && ex_mem_read && (ex_rd != 5'd0) &&
                     ((w_rs1Used && (w_rs1 == ex_rd)) || (w_rs2Used && (w_rs2 == ex_rd)));

  // r_armed stays low for the first edge after reset release so start is ignored there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_drainCnt <= 2'd0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_drainCnt <= w_nextDrainCnt;
      r_armed    <= 1'b1;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_nextDrainCnt = r_drainCnt;
    case (r_state)
      IDLE: begin
        if (start && r_armed) w_nextState = RUN;
      end
      RUN: begin
        if (!branch_taken && w_halt) begin
          w_nextState    = DRAIN;
          w_nextDrainCnt = 2'd0;
        end
      end
      DRAIN: begin
        if (branch_taken) begin
          w_nextState    = RUN;
          w_nextDrainCnt = 2'd0;
        end else if (r_drainCnt == 2'd2) begin
          w_nextState    = HALTED;
          w_nextDrainCnt = 2'd0;
        end else begin
          w_nextDrainCnt = r_drainCnt + 2'd1;
        end
      end
      HALTED: begin
        w_nextState = HALTED;
      end
      default: begin
        w_nextState    = IDLE;
        w_nextDrainCnt = 2'd0;
      end
    endcase
  end

  // Priority inside RUN: branch flush, then halt (no special control), then load-use stall.
  always_comb begin
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (r_state)
      RUN: begin
        if (branch_taken) begin
          pc_we      = 1'b1;
          ifid_we    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (!w_halt && w_loadUse) begin
          idex_flush = 1'b1;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end
      end
      DRAIN: begin
        if (branch_taken) begin
          pc_we      = 1'b1;
          ifid_we    = 1'b1;
          ifid_flush = 1'b1;
        end
        idex_flush = 1'b1;
      end
      default: begin
        pc_we = 1'b0;
      end
    endcase
  end

  assign done  = (r_state == HALTED);
  assign state = r_state;

`ifdef PIPE_CTRL_PERF_EN
  logic        w_stallEvt;
  logic        w_flushEvt;
  logic [15:0] r_stallCnt;
  logic [15:0] r_flushCnt;

  assign w_stallEvt = (r_state == RUN) && !branch_taken && !w_halt && w_loadUse;
  assign w_flushEvt = ((r_state == RUN) || (r_state == DRAIN)) && branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt <= 16'd0;
      r_flushCnt <= 16'd0;
    end else begin
      if (w_stallEvt && (r_stallCnt != 16'hFFFF)) r_stallCnt <= r_stallCnt + 16'd1;
      if (w_flushEvt && (r_flushCnt != 16'hFFFF)) r_flushCnt <= r_flushCnt + 16'd1;
    end
  end

  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: vector table in RUN plus halt/drain/reset sequences.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        branch_taken;
  logic        pc_we;
  logic        ifid_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic        done;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int checks;
  int failures;
  int expStall;
  int expFlush;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        memRead;
    logic [4:0]  rd;
    logic        branch;
    logic [3:0]  expCtl;
    int          stallInc;
    int          flushInc;
  } vec_t;

  vec_t vecs[15];

  pipe_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .branch_taken (branch_taken),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .done         (done),
    .state        (state),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    id_instr     = v.instr;
    id_valid     = v.valid;
    ex_mem_read  = v.memRead;
    ex_rd        = v.rd;
    branch_taken = v.branch;
  endtask

  task automatic checkCtl(input string name, input logic [3:0] exp);
    checkOutput(name, {28'd0, pc_we, ifid_we, ifid_flush, idex_flush}, {28'd0, exp});
  endtask

  task automatic checkCounters(input string name);
    checkOutput({name, "_stall"}, {16'd0, stall_cnt}, PerfEn ? expStall : 0);
    checkOutput({name, "_flush"}, {16'd0, flush_cnt}, PerfEn ? expFlush : 0);
  endtask

  task automatic idleInputs();
    start        = 1'b0;
    id_instr     = 32'h0000_0013;
    id_valid     = 1'b0;
    ex_mem_read  = 1'b0;
    ex_rd        = 5'd0;
    branch_taken = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n    = 1'b1;
    expStall = 0;
    expFlush = 0;
  endtask

  // Release happens at a negedge, so the first posedge is the ignored one.
  task automatic goRun();
    @(negedge clk);
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("go_run_state", {30'd0, state}, 32'd1);
  endtask

  task automatic enterDrain();
    @(negedge clk);
    id_instr = 32'h0000_0073;
    id_valid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("enter_drain_state", {30'd0, state}, 32'd2);
    @(negedge clk);
    id_instr = 32'h0000_0013;
    id_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    expStall = 0;
    expFlush = 0;

    //            instr          vld  mrd  rd     br    {pc,ifwe,iffl,idfl} stall flush
    vecs[0]  = '{32'h0000_0013, 1'b1, 1'b0, 5'd0, 1'b0, 4'b1100, 0, 0};
    vecs[1]  = '{32'h0040_81b3, 1'b1, 1'b1, 5'd1, 1'b0, 4'b0001, 1, 0};
    vecs[2]  = '{32'h0000_82b7, 1'b1, 1'b1, 5'd1, 1'b0, 4'b1100, 0, 0};
    vecs[3]  = '{32'h0000_01b3, 1'b1, 1'b1, 5'd0, 1'b0, 4'b1100, 0, 0};
    vecs[4]  = '{32'h0040_81b3, 1'b1, 1'b1, 5'd4, 1'b0, 4'b0001, 1, 0};
    vecs[5]  = '{32'h0040_8193, 1'b1, 1'b1, 5'd4, 1'b0, 4'b1100, 0, 0};
    vecs[6]  = '{32'h0051_2023, 1'b1, 1'b1, 5'd5, 1'b0, 4'b0001, 1, 0};
    vecs[7]  = '{32'h0040_81b3, 1'b0, 1'b1, 5'd1, 1'b0, 4'b1100, 0, 0};
    vecs[8]  = '{32'h0040_81b3, 1'b1, 1'b0, 5'd1, 1'b0, 4'b1100, 0, 0};
    vecs[9]  = '{32'h0040_81b3, 1'b1, 1'b1, 5'd1, 1'b1, 4'b1111, 0, 1};
    vecs[10] = '{32'h0000_0013, 1'b1, 1'b0, 5'd0, 1'b1, 4'b1111, 0, 1};
    vecs[11] = '{32'h0000_0073, 1'b1, 1'b0, 5'd0, 1'b1, 4'b1111, 0, 1};
    vecs[12] = '{32'h0000_8097, 1'b1, 1'b1, 5'd1, 1'b0, 4'b1100, 0, 0};
    vecs[13] = '{32'h0000_80ef, 1'b1, 1'b1, 5'd1, 1'b0, 4'b1100, 0, 0};
    vecs[14] = '{32'h0000_80e7, 1'b1, 1'b1, 5'd1, 1'b0, 4'b0001, 1, 0};

    idleInputs();
    rst_n = 1'b0;
    #3;
    checkOutput("reset_state", {30'd0, state}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkCtl("reset_ctl", 4'b0000);
    checkCounters("reset");
    #9;
    @(negedge clk);
    rst_n = 1'b1;

    goRun();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkCtl($sformatf("vec%0d_ctl", i), vecs[i].expCtl);
      @(posedge clk);
      #1;
      expStall += vecs[i].stallInc;
      expFlush += vecs[i].flushInc;
      checkOutput($sformatf("vec%0d_state", i), {30'd0, state}, 32'd1);
      checkCounters($sformatf("vec%0d", i));
    end
    idleInputs();

    // Halt: three DRAIN cycles, then HALTED ignores start.
    enterDrain();
    #1;
    checkCtl("drain_ctl", 4'b0001);
    checkOutput("drain_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("drain2_state", {30'd0, state}, 32'd2);
    @(posedge clk);
    #1;
    checkOutput("drain3_state", {30'd0, state}, 32'd2);
    @(posedge clk);
    #1;
    checkOutput("halted_state", {30'd0, state}, 32'd3);
    checkOutput("halted_done", {31'd0, done}, 32'd1);
    checkCtl("halted_ctl", 4'b0000);
    @(negedge clk);
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("halted_start_state", {30'd0, state}, 32'd3);
    checkCounters("halted");

    // Branch in DRAIN returns to RUN and restarts the drain count.
    doReset();
    goRun();
    enterDrain();
    branch_taken = 1'b1;
    #1;
    checkCtl("drain_branch_ctl", 4'b1111);
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    expFlush++;
    checkOutput("drain_branch_state", {30'd0, state}, 32'd1);
    checkCounters("drain_branch");
    enterDrain();
    @(posedge clk);
    #1;
    checkOutput("redrain2_state", {30'd0, state}, 32'd2);
    @(posedge clk);
    #1;
    checkOutput("redrain3_state", {30'd0, state}, 32'd2);
    @(posedge clk);
    #1;
    checkOutput("redrain_halted", {30'd0, state}, 32'd3);

    // Asynchronous reset in the second DRAIN cycle, then start ignored on release edge.
    doReset();
    goRun();
    @(negedge clk);
    applyStimulus(vecs[1]);
    @(posedge clk);
    #1;
    expStall++;
    @(negedge clk);
    applyStimulus(vecs[10]);
    @(posedge clk);
    #1;
    expFlush++;
    idleInputs();
    checkCounters("pre_reset");
    enterDrain();
    @(posedge clk);
    #1;
    checkOutput("mid_drain_state", {30'd0, state}, 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    expStall = 0;
    expFlush = 0;
    checkOutput("async_reset_state", {30'd0, state}, 32'd0);
    checkCtl("async_reset_ctl", 4'b0000);
    checkOutput("async_reset_done", {31'd0, done}, 32'd0);
    checkCounters("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_edge_state", {30'd0, state}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("after_release_state", {30'd0, state}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
